// File: rtl/aes_tx_sched_if.sv
// Bundle of the requester handshakes and the shared byte-serial TX port.
// The slave modport is the scheduler's view; the master modport drives it.
interface aes_tx_sched_if;
  logic         en;
  logic [127:0] data0;
  logic         req0;
  logic         ack0;
  logic [127:0] data1;
  logic         req1;
  logic         ack1;
  logic [7:0]   tx;
  logic         shakehand;
  logic         busy;
  logic         frame_done;

  modport slave (
    input  en, data0, req0, data1, req1,
    output ack0, ack1, tx, shakehand, busy, frame_done
  );

  modport master (
    output en, data0, req0, data1, req1,
    input  ack0, ack1, tx, shakehand, busy, frame_done
  );
endinterface

// File: rtl/aes_tx_sched.sv
// Round-robin scheduler sending 17-byte frames (header + 16 data bytes,
// MSB first) from two 128-bit requesters over one byte-serial TX port.
module aes_tx_sched (
  input  logic           clk,
  input  logic           rst,
  aes_tx_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_DATA = 2'd2
  } state_e;

  localparam logic [6:0] HDR_TAG = 7'b1010_000;

  state_e       state_q,      state_d;
  logic [3:0]   cnt_q,        cnt_d;
  logic [7:0]   tx_q,         tx_d;
  logic         shake_q,      shake_d;
  logic         busy_q,       busy_d;
  logic         ack0_q,       ack0_d;
  logic         ack1_q,       ack1_d;
  logic         frame_done_q, frame_done_d;
  logic         last_grant_q, last_grant_d;
  logic [127:0] block_q,      block_d;

  logic grant0;
  logic grant1;
  logic slot;

  // Byte k of the latched block, byte 0 being bits [127:120].
  function automatic logic [7:0] block_byte(input logic [127:0] blk,
                                            input logic [3:0]   k);
    logic [127:0] shifted;
    shifted = blk << {k, 3'b000};
    return shifted[127:120];
  endfunction

  always_comb begin
    // NOTE: every comb output gets a default first so no path infers a latch.
    state_d      = state_q;
    cnt_d        = cnt_q;
    tx_d         = tx_q;
    shake_d      = shake_q;
    busy_d       = busy_q;
    last_grant_d = last_grant_q;
    block_d      = block_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    frame_done_d = 1'b0;

    // On a tie, requester 0 wins only if requester 1 was granted last.
    grant0 = bus.req0 && (!bus.req1 || last_grant_q);
    grant1 = bus.req1 && !grant0;

    slot = bus.en && ((state_q == S_IDLE) ||
                      ((state_q == S_DATA) && (cnt_q == 4'd15)));

    if (slot) begin
      if (grant0 || grant1) begin
        block_d      = grant1 ? bus.data1 : bus.data0;
        last_grant_d = grant1;
        ack0_d       = grant0;
        ack1_d       = grant1;
        tx_d         = {HDR_TAG, grant1};
        shake_d      = ~shake_q;
        busy_d       = 1'b1;
        cnt_d        = 4'd0;
        state_d      = S_HDR;
      end else begin
        tx_d    = 8'h00;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    end else if (bus.en) begin
      case (state_q)
        S_HDR: begin
          tx_d    = block_byte(block_q, 4'd0);
          cnt_d   = 4'd0;
          shake_d = ~shake_q;
          state_d = S_DATA;
        end
        S_DATA: begin
          // Counter is below 15 here; the counter=15 case is a slot.
          cnt_d        = cnt_q + 4'd1;
          tx_d         = block_byte(block_q, cnt_q + 4'd1);
          shake_d      = ~shake_q;
          frame_done_d = (cnt_q == 4'd14);
        end
        default: ;
      endcase
    end
  end

  // NOTE: the 128-bit block register is reset too, so an aborted frame leaves
  // no stale data behind; it is ordinary flops, not a memory array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      tx_q         <= 8'h00;
      shake_q      <= 1'b0;
      busy_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      frame_done_q <= 1'b0;
      last_grant_q <= 1'b1;
      block_q      <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      tx_q         <= tx_d;
      shake_q      <= shake_d;
      busy_q       <= busy_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      frame_done_q <= frame_done_d;
      last_grant_q <= last_grant_d;
      block_q      <= block_d;
    end
  end

  assign bus.ack0       = ack0_q;
  assign bus.ack1       = ack1_q;
  assign bus.tx         = tx_q;
  assign bus.shakehand  = shake_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_aes_tx_sched.sv
// Self-checking bench: requester queues feed the scheduler while a byte-queue
// reference model predicts tx/shakehand/busy/ack/frame_done every cycle.
module tb_aes_tx_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_tx_sched_if bus();

  aes_tx_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Requester-side block queues; req is high while a queue holds a block.
  logic [127:0] q0[$];
  logic [127:0] q1[$];
  bit           mask0 = 1'b1;
  bit           mask1 = 1'b1;

  // Reference model: bytes still to send in the current frame.
  logic [7:0] m_bytes[$];
  logic [7:0] exp_tx;
  logic       exp_sh, exp_busy, exp_ack0, exp_ack1, exp_fd, m_last;
  int         grants[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [7:0] obs,
                       input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, "_tx"},    bus.tx,                exp_tx);
    check({ctx, "_shake"}, {7'd0, bus.shakehand}, {7'd0, exp_sh});
    check({ctx, "_busy"},  {7'd0, bus.busy},      {7'd0, exp_busy});
    check({ctx, "_ack0"},  {7'd0, bus.ack0},      {7'd0, exp_ack0});
    check({ctx, "_ack1"},  {7'd0, bus.ack1},      {7'd0, exp_ack1});
    check({ctx, "_fdone"}, {7'd0, bus.frame_done},{7'd0, exp_fd});
  endtask

  task automatic model_reset();
    m_bytes.delete();
    exp_tx   = 8'h00;
    exp_sh   = 1'b0;
    exp_busy = 1'b0;
    exp_ack0 = 1'b0;
    exp_ack1 = 1'b0;
    exp_fd   = 1'b0;
    m_last   = 1'b1;
  endtask

  task automatic reset_pulse(input int cycles);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst_async");
    repeat (cycles) @(posedge clk);
    #1;
    check_outputs("rst_hold");
    rst = 1'b0;
  endtask

  // One clock: drive inputs, predict, clock, compare, then requesters pop.
  task automatic step(input bit en_i);
    logic         r0, r1;
    logic [127:0] d0, d1, blk;
    int           win;
    r0 = (q0.size() > 0) && mask0;
    r1 = (q1.size() > 0) && mask1;
    d0 = (q0.size() > 0) ? q0[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
    d1 = (q1.size() > 0) ? q1[0] : {$urandom(), $urandom(), $urandom(), $urandom()};
    bus.en    = en_i;
    bus.req0  = r0;
    bus.data0 = d0;
    bus.req1  = r1;
    bus.data1 = d1;

    exp_ack0 = 1'b0;
    exp_ack1 = 1'b0;
    exp_fd   = 1'b0;
    win      = -1;
    if (en_i) begin
      if (m_bytes.size() != 0) begin
        exp_tx = m_bytes.pop_front();
        exp_sh = ~exp_sh;
        exp_fd = (m_bytes.size() == 0);
      end else begin
        if (r0 && r1) win = m_last ? 0 : 1;
        else if (r0)  win = 0;
        else if (r1)  win = 1;
        if (win >= 0) begin
          blk    = (win == 1) ? d1 : d0;
          exp_tx = 8'hA0 | win[7:0];
          for (int k = 0; k < 16; k++) m_bytes.push_back(blk[127 - 8*k -: 8]);
          exp_sh   = ~exp_sh;
          exp_busy = 1'b1;
          m_last   = win[0];
          exp_ack0 = (win == 0);
          exp_ack1 = (win == 1);
          grants.push_back(win);
        end else begin
          exp_tx   = 8'h00;
          exp_busy = 1'b0;
        end
      end
    end

    @(posedge clk);
    #1;
    check_outputs("cyc");
    if (win == 0) void'(q0.pop_front());
    if (win == 1) void'(q1.pop_front());
  endtask

  function automatic logic [127:0] rand_block();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    int g;
    bus.en    = 1'b0;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.data0 = '0;
    bus.data1 = '0;
    reset_pulse(2);

    // Single request with the counting pattern, en every cycle.
    q0.push_back(128'h000102030405060708090A0B0C0D0E0F);
    repeat (22) step(1'b1);
    check("single_grants", 8'(grants.size()), 8'd1);

    // Tie right after reset: 0 then 1, back to back.
    reset_pulse(1);
    grants.delete();
    q0.push_back(rand_block());
    q1.push_back(rand_block());
    repeat (40) step(1'b1);
    g = (grants.size() > 0) ? grants[0] : -1;
    check("tie_first", 8'(g), 8'd0);
    g = (grants.size() > 1) ? grants[1] : -1;
    check("tie_second", 8'(g), 8'd1);

    // Sparse en: one strobe in four cycles.
    q0.push_back(rand_block());
    for (int i = 0; i < 80; i++) step(i % 4 == 0);

    // Reset at data byte 7, then requester 1 gets a fresh frame.
    q0.push_back(rand_block());
    repeat (9) step(1'b1);
    q1.push_back(rand_block());
    reset_pulse(2);
    grants.delete();
    repeat (20) step(1'b1);
    g = (grants.size() > 0) ? grants[0] : -1;
    check("post_rst_grant", 8'(g), 8'd1);

    // Requester 1 held high while requester 0 issues three blocks.
    grants.delete();
    repeat (3) q0.push_back(rand_block());
    repeat (4) q1.push_back(rand_block());
    repeat (7 * 17 + 5) step(1'b1);
    for (int i = 0; i < 6; i++) begin
      g = (i < grants.size()) ? grants[i] : -1;
      check($sformatf("alt%0d", i), 8'(g), 8'(i % 2));
    end

    // Randomised traffic: random en, arrivals and transient req drops.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(15) == 0 && q0.size() < 4) q0.push_back(rand_block());
      if ($urandom_range(15) == 0 && q1.size() < 4) q1.push_back(rand_block());
      if ($urandom_range(7) == 0) mask0 = ~mask0;
      if ($urandom_range(7) == 0) mask1 = ~mask1;
      step($urandom_range(3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_tx_sched.md
AES_TX_SCHED -- requirements
Module: aes_tx_sched

Interface
REQ-001: clk  input  1  single system clock; all state updates on rising edge.
REQ-002: rst  input  1  asynchronous, active-high reset.
REQ-003: en  input  1  byte-slot strobe; sequencing advances only in cycles with en=1.
REQ-004: data0  input  128  result block from requester 0, valid while req0=1.
REQ-005: req0  input  1  requester 0 holds a block (queue not empty).
REQ-006: ack0  output  1  one-clk pop pulse to requester 0 when its block is taken.
REQ-007: data1  input  128  result block from requester 1, valid while req1=1.
REQ-008: req1  input  1  requester 1 holds a block.
REQ-009: ack1  output  1  one-clk pop pulse to requester 1.
REQ-010: tx  output  8  byte currently presented on the shared port.
REQ-011: shakehand  output  1  toggles once per new byte placed on tx.
REQ-012: busy  output  1  high while a frame is in progress.
REQ-013: frame_done  output  1  one-clk pulse after the last data byte of a frame is placed on tx.

Function
REQ-014: The block SHALL share one byte-serial TX port between two 128-bit requesters, sending one 17-byte frame per granted block.
REQ-015: Frame = header byte {7'b1010_000, src} followed by 16 data bytes, MSB first; data byte k = block[127-8k -: 8], k=0..15.
REQ-016: States: IDLE, HDR, DATA; a 4-bit byte counter indexes DATA.
REQ-017: Arbitration slot = any en=1 cycle in IDLE, or the en=1 cycle in DATA with counter=15.
REQ-018: At a slot with exactly one req high, that requester SHALL be granted.
REQ-019: At a slot with both req high, the requester not granted most recently SHALL win (round-robin); last_grant resets to 1, so requester 0 wins the first tie.
REQ-020: On grant: latch the winner's data and src, set ackN=1 for the following clk only, put the header on tx, toggle shakehand, set busy=1, go to HDR.
REQ-021: At a slot with no req: go to or stay in IDLE, busy=0, tx=8'h00, shakehand held.
REQ-022: HDR + en: put data byte 0 on tx, counter=0, toggle shakehand, go to DATA.
REQ-023: DATA + en with counter<15: increment counter, put byte counter+1 on tx, toggle shakehand; after byte 15 is loaded, pulse frame_done for one clk.
REQ-024: The slot at counter=15 SHALL start the next frame with no idle byte when any req is high (back-to-back frames).
REQ-025: When en=0: state, counter, tx, shakehand, busy and the latched block SHALL hold; ack0/ack1 SHALL be 0.
REQ-026: ack0 and ack1 SHALL never be high together; at most one ack per frame.
REQ-027: req or data changes after grant SHALL NOT affect the frame in flight; the latched copy is sent.
REQ-028: A requester that drops req before a slot SHALL NOT be granted at that slot.

Reset
REQ-029: While rst=1: state=IDLE, counter=0, tx=8'h00, shakehand=0, ack0=ack1=0, busy=0, frame_done=0, last_grant=1, latched block=0.
REQ-030: rst asserted mid-frame SHALL abort the frame immediately; the popped block is discarded and no ack is reissued.

Verification
REQ-031: Single request: req0=1, data0=128'h000102...0F, en every cycle -> ack0 one pulse; tx sequence A0,00,01,...,0F; 17 shakehand toggles; one frame_done; then tx=00, busy=0.
REQ-032: Tie after reset: req0=req1=1 -> frame src 0 (header A0), then back-to-back frame src 1 (header A1) with no gap byte; ack0 then ack1, never overlapping.
REQ-033: Sparse en (1 in 4 cycles) during a frame -> tx and shakehand change only in cycles following en=1; ack stays one clk wide.
REQ-034: Change data0 and drop req0 one cycle after ack0 -> transmitted bytes still match the block latched at grant.
REQ-035: Pulse rst at data byte 7 -> all outputs at reset values next cycle; on release with req1=1 -> fresh frame with header A1 starting at byte 0.
REQ-036: Requester 1 held high continuously while requester 0 issues 3 blocks -> grants strictly alternate 0,1,0,1,0,...
